// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the core's fetch and data accesses,
// sequencing fetch -> optional data access -> commit and stalling the core so each instruction commits once.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] IM_addr,
    output logic [DATA_WIDTH-1:0] IM_rdata,
    output logic                  IM_stall,
    input  logic                  DM_REQ,
    input  logic [ADDR_WIDTH-1:0] DM_addr,
    input  logic [DATA_WIDTH-1:0] DM_wdata,
    input  logic                  DM_WEN,
    output logic [DATA_WIDTH-1:0] DM_rdata,
    output logic                  DM_stall,
    input  logic                  HALT,
    output logic                  MEM_req,
    output logic [ADDR_WIDTH-1:0] MEM_addr,
    output logic [DATA_WIDTH-1:0] MEM_wdata,
    output logic                  MEM_WEN,
    input  logic                  MEM_ready,
    input  logic [DATA_WIDTH-1:0] MEM_rdata,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DATA, COMMIT, HALTED} state_t;
    localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT - 1);
    state_t                state_q, state_d;
    logic [15:0]           wait_q, wait_d;
    logic [DATA_WIDTH-1:0] im_q, im_d, dm_q, dm_d;
    logic                  err_q, err_d;
    logic                  done, expire;
    always_comb begin
        MEM_req   = state_q == FETCH || state_q == DATA;
        MEM_addr  = state_q == DATA ? DM_addr : IM_addr;
        MEM_wdata = DM_wdata;
        MEM_WEN   = state_q == DATA && DM_WEN;
        IM_stall  = state_q == IDLE || state_q == FETCH || state_q == HALTED;
        DM_stall  = state_q == EXEC ? DM_REQ : state_q != COMMIT;
        done      = MEM_req && MEM_ready;
        // the last waiting cycle before the limit is where ready still wins
        expire    = MEM_req && !MEM_ready && wait_q == WAIT_LIM;
        wait_d    = MEM_req && !MEM_ready ? wait_q + 16'd1 : 16'd0;
        im_d      = state_q == FETCH && done ? MEM_rdata : im_q;
        dm_d      = state_q == DATA && done && !DM_WEN ? MEM_rdata : dm_q;
        err_d     = err_q || expire;
        state_d   = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = done ? EXEC : expire ? HALTED : FETCH;
            EXEC:    state_d = HALT ? HALTED : DM_REQ ? DATA : FETCH;
            DATA:    state_d = done ? COMMIT : expire ? HALTED : DATA;
            COMMIT:  state_d = FETCH;
            default: state_d = HALTED;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            wait_q  <= '0;
            im_q    <= '0;
            dm_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            im_q    <= im_d;
            dm_q    <= dm_d;
            err_q   <= err_d;
        end
    end
    assign IM_rdata = im_q;
    assign DM_rdata = dm_q;
    assign err      = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives instruction sequences through the arbiter against a variable-latency memory
// and checks every cycle against the waveform implied by each instruction's fetch/data latencies.
module tb_mem_port_arbiter;
    logic        CLK = 0, RST = 0;
    logic [31:0] IM_addr = 0, IM_rdata, DM_addr = 0, DM_wdata = 0, DM_rdata;
    logic        IM_stall, DM_REQ = 0, DM_WEN = 0, DM_stall, HALT = 0;
    logic        MEM_req, MEM_WEN, MEM_ready = 0, err;
    logic [31:0] MEM_addr, MEM_wdata, MEM_rdata = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .IM_addr(IM_addr), .IM_rdata(IM_rdata), .IM_stall(IM_stall),
        .DM_REQ(DM_REQ), .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_WEN(DM_WEN),
        .DM_rdata(DM_rdata), .DM_stall(DM_stall), .HALT(HALT), .MEM_req(MEM_req),
        .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_WEN(MEM_WEN), .MEM_ready(MEM_ready),
        .MEM_rdata(MEM_rdata), .err(err)
    );

    always #5 CLK = ~CLK;

    int          errors = 0, checks = 0, cyc = 0, waited = 0, wr_cnt = 0, exec_cyc = 0;
    int          lat_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] last_wa = 0, last_wd = 0, dm_exp = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    always @(posedge CLK) cyc++;

    // memory: each request completes after the number of wait cycles at the head of lat_q
    always @(negedge CLK) begin
        MEM_ready = MEM_req && lat_q.size() > 0 && waited == lat_q[0];
        MEM_rdata = mem_rd(MEM_addr);
    end
    always @(posedge CLK) begin
        if (MEM_req && MEM_ready) begin
            if (MEM_WEN) begin
                mem[MEM_addr] = MEM_wdata;
                wr_cnt++;
                last_wa = MEM_addr;
                last_wd = MEM_wdata;
            end
            void'(lat_q.pop_front());
            waited = 0;
        end else if (MEM_req) waited++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string nm, input logic e);
        chk({nm, "_req"}, 32'(MEM_req), 0);
        chk({nm, "_wen"}, 32'(MEM_WEN), 0);
        chk({nm, "_ims"}, 32'(IM_stall), 1);
        chk({nm, "_dms"}, 32'(DM_stall), 1);
        chk({nm, "_err"}, 32'(err), 32'(e));
    endtask

    task automatic do_reset();
        #2 RST = 0;
        lat_q.delete();
        waited = 0;
        dm_exp = 0;
        #1;
        idle_chk("rst", 0);
        chk("rst_imr", IM_rdata, 0);
        chk("rst_dmr", DM_rdata, 0);
        @(negedge CLK) RST = 1;
        #1 idle_chk("idle", 0);
    endtask

    task automatic run_instr(input logic [31:0] pc, input logic dmreq, input logic wen,
                             input logic [31:0] daddr, input logic [31:0] wdata,
                             input int lf, input int ld, input logic halt, input int abort);
        logic [31:0] ir = mem_rd(pc), ldv = mem_rd(daddr);
        int wr0 = wr_cnt;
        @(posedge CLK); #1;
        IM_addr = pc; DM_REQ = dmreq; DM_WEN = wen; DM_addr = daddr; DM_wdata = wdata; HALT = halt;
        lat_q.push_back(lf);
        if (dmreq) lat_q.push_back(ld);
        for (int c = 0; c <= lf; c++) begin
            @(negedge CLK);
            chk("f_req", 32'(MEM_req), 1);
            chk("f_addr", MEM_addr, pc);
            chk("f_wen", 32'(MEM_WEN), 0);
            chk("f_ims", 32'(IM_stall), 1);
            chk("f_dms", 32'(DM_stall), 1);
            chk("f_err", 32'(err), 0);
        end
        @(negedge CLK);
        exec_cyc = cyc;
        chk("x_req", 32'(MEM_req), 0);
        chk("x_wen", 32'(MEM_WEN), 0);
        chk("x_ims", 32'(IM_stall), 0);
        chk("x_dms", 32'(DM_stall), 32'(dmreq));
        chk("x_imr", IM_rdata, ir);
        chk("x_dmr", DM_rdata, dm_exp);
        if (halt) begin
            repeat (22) begin
                @(posedge CLK); #1 HALT = 1'($urandom);
                @(negedge CLK) idle_chk("halt", 0);
            end
            HALT = 0;
            return;
        end
        if (!dmreq) return;
        for (int c = 0; c <= ld; c++) begin
            @(negedge CLK);
            chk("d_req", 32'(MEM_req), 1);
            chk("d_addr", MEM_addr, daddr);
            chk("d_wen", 32'(MEM_WEN), 32'(wen));
            if (wen) chk("d_wdata", MEM_wdata, wdata);
            chk("d_ims", 32'(IM_stall), 0);
            chk("d_dms", 32'(DM_stall), 1);
            chk("d_imr", IM_rdata, ir);
            chk("d_err", 32'(err), 0);
            if (c == abort) begin
                do_reset();
                return;
            end
        end
        if (!wen) dm_exp = ldv;
        @(negedge CLK);
        chk("c_req", 32'(MEM_req), 0);
        chk("c_ims", 32'(IM_stall), 0);
        chk("c_dms", 32'(DM_stall), 0);
        chk("c_imr", IM_rdata, ir);
        chk("c_dmr", DM_rdata, dm_exp);
        chk("c_writes", 32'(wr_cnt - wr0), 32'(wen));
        if (wen) begin
            chk("c_waddr", last_wa, daddr);
            chk("c_wdata", last_wd, wdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int e[3];
        logic [31:0] pc;
        mem[32'h100] = 32'hDEADBEEF;
        #3;
        idle_chk("por", 0);
        chk("por_imr", IM_rdata, 0);
        chk("por_dmr", DM_rdata, 0);
        @(negedge CLK) RST = 1;
        #1 idle_chk("idle0", 0);
        for (int i = 0; i < 3; i++) begin
            run_instr(32'(4 * i), 0, 0, 0, 0, 0, 0, 0, -1);
            e[i] = exec_cyc;
        end
        chk("period01", 32'(e[1] - e[0]), 2);
        chk("period12", 32'(e[2] - e[1]), 2);
        run_instr(32'h10, 1, 0, 32'h100, 0, 0, 3, 0, -1);
        chk("lw_lit", DM_rdata, 32'hDEADBEEF);
        run_instr(32'h14, 1, 1, 32'h200, 32'h12345678, 2, 1, 0, -1);
        chk("sw_dmr_lit", DM_rdata, 32'hDEADBEEF);
        chk("sw_wd_lit", mem_rd(32'h200), 32'h12345678);
        run_instr(32'h18, 1, 0, 32'h100, 0, 1, 3, 0, 1);
        run_instr(32'h18, 1, 0, 32'h100, 0, 0, 0, 0, -1);
        chk("rerun_lit", DM_rdata, 32'hDEADBEEF);
        pc = 32'h1000;
        for (int i = 0; i < 60; i++) begin
            run_instr(pc, 1'($urandom), 1'($urandom), 32'h200 + 32'(4 * $urandom_range(0, 7)),
                      $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
            pc += 4;
        end
        run_instr(pc, 0, 0, 0, 0, 1, 0, 1, -1);
        do_reset();
        @(posedge CLK); #1;
        IM_addr = 32'h40; DM_REQ = 0; HALT = 0;
        lat_q.push_back(1000);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("to_req", 32'(MEM_req), 1);
            chk("to_err", 32'(err), 0);
            chk("to_ims", 32'(IM_stall), 1);
        end
        @(negedge CLK);
        chk("to_err_lit", 32'(err), 1);
        repeat (15) @(negedge CLK) idle_chk("to_hold", 1);
        do_reset();
        run_instr(32'h44, 1, 0, 32'h100, 0, 3, 2, 0, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the single-cycle core's instruction and data interfaces.
- Sequences each instruction as: fetch, then an optional data access, then one commit cycle.
- Drives the core's IM_stall and DM_stall so that the PC and the register file update exactly once per instruction.
- Sits between Core and the unified memory model in the top-level testbench.

Parameters:
ADDR_WIDTH, 32, address width of all address ports
DATA_WIDTH, 32, data width of all data ports
TIMEOUT, 255, maximum cycles to wait for MEM_ready before flagging an error (valid range 1..65535)

Ports:
CLK  input  1  clock; all state is updated on the rising edge
RST  input  1  reset, asynchronous, active-low
IM_addr  input  ADDR_WIDTH  core fetch address (PC)
IM_rdata  output  DATA_WIDTH  latched instruction, held stable from fetch completion until the next fetch completes
IM_stall  output  1  instruction stall to core
DM_REQ  input  1  core-decoded lw/sw of the current instruction
DM_addr  input  ADDR_WIDTH  data address
DM_wdata  input  DATA_WIDTH  store data
DM_WEN  input  1  1 = store, 0 = load; sampled only in DATA
DM_rdata  output  DATA_WIDTH  latched load data
DM_stall  output  1  data stall to core
HALT  input  1  core finish (syscall)
MEM_req  output  1  memory request
MEM_addr  output  ADDR_WIDTH  memory address
MEM_wdata  output  DATA_WIDTH  memory write data
MEM_WEN  output  1  memory write enable
MEM_ready  input  1  memory completion
MEM_rdata  input  DATA_WIDTH  memory read data
err  output  1  sticky timeout flag

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-low.
- Reset (RST=0):
  - State goes to IDLE and wait_cnt to 0.
  - IM_rdata=0, DM_rdata=0, err=0.
  - MEM_req=0, MEM_WEN=0, IM_stall=1, DM_stall=1.
  - Reset mid-transaction abandons the request; the memory model tolerates MEM_req dropping without MEM_ready.
- IDLE: IM_stall=1, DM_stall=1, no request. Goes to FETCH on the next edge after reset release.
- FETCH:
  - Outputs: MEM_req=1, MEM_addr=IM_addr, MEM_WEN=0, IM_stall=1, DM_stall=1.
  - A transfer completes in any cycle where MEM_req=1 and MEM_ready=1; zero-wait memory (MEM_ready=1 in the first request cycle) is legal.
  - On completion: IM_rdata<=MEM_rdata, go to EXEC.
- EXEC:
  - Outputs: MEM_req=0, IM_stall=0, DM_stall=DM_REQ.
  - HALT=1: go to HALTED. The stalls in this cycle are as above; the syscall commits no register write.
  - Else DM_REQ=0: this is the commit cycle (PC advances); go to FETCH.
  - Else go to DATA.
- DATA:
  - Outputs: MEM_req=1, MEM_addr=DM_addr, MEM_wdata=DM_wdata, MEM_WEN=DM_WEN, IM_stall=0, DM_stall=1.
  - On completion: if DM_WEN=0, DM_rdata<=MEM_rdata; stores leave DM_rdata unchanged. Go to COMMIT.
- COMMIT: IM_stall=0, DM_stall=0, no request (commit cycle for lw/sw). Go to FETCH.
- HALTED:
  - Outputs: IM_stall=1, DM_stall=1, no request.
  - Left only by reset; the HALT input is ignored here.
- MEM_addr, MEM_wdata and MEM_WEN are don't-care when MEM_req=0; MEM_WEN is driven 0 whenever MEM_req=0.
- Timeout:
  - wait_cnt (16 bits) clears on entry to FETCH or DATA and increments each cycle MEM_req=1 and MEM_ready=0.
  - When wait_cnt reaches TIMEOUT with MEM_ready still 0: set err=1 (sticky until reset) and go to HALTED.
  - MEM_ready=1 in that same cycle takes priority: the transfer completes and no error is raised.
- Per-instruction cost:
  - Non-memory instruction: fetch latency + 1 cycles.
  - lw/sw: fetch latency + data latency + 2 cycles.
- The PC never advances twice per instruction: exactly one cycle per instruction has the relevant stall low.

Test Plan:
- Zero-wait memory, three addiu at 0x0,0x4,0x8 -> MEM_addr sequence 0x0,0x4,0x8; a 2-cycle period per instruction; IM_stall low exactly once per instruction.
- lw at 0x10 with DM_addr=0x100, memory returns 0xDEADBEEF after 3 wait cycles -> DATA holds MEM_addr=0x100 and MEM_WEN=0 for 4 cycles; DM_rdata=0xDEADBEEF; DM_stall low for exactly one cycle (COMMIT).
- sw DM_addr=0x200, DM_wdata=0x12345678 -> exactly one completed transfer with MEM_WEN=1 and that data; DM_rdata unchanged; IM_rdata stable throughout.
- TIMEOUT=4 with MEM_ready held 0 during FETCH -> err=1 after 4 waiting cycles; stalls stay 1; no further MEM_req until reset.
- HALT asserted with the syscall in EXEC -> HALTED; MEM_req stays 0 for 20+ cycles while HALT toggles.
- RST pulled low mid-DATA -> MEM_req=0, IM_rdata=0, DM_rdata=0 and err=0 immediately (asynchronously); after release, IDLE then FETCH of the current IM_addr.
